// File: rtl/arbitro_compuerta_pkg.sv
// Shared types and constants for the two-lane barrier controller.
package arbitro_pkg;

  typedef enum logic [2:0] {
    CERRADO    = 3'd0,
    ESPERA_PIN = 3'd1,
    ALARMA     = 3'd2,
    ABIERTO    = 3'd3,
    BLOQUEO    = 3'd4
  } estado_t;

  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

  localparam logic [7:0] PIN_DEFAULT = 8'h10;

endpackage

// File: rtl/arbitro_compuerta_if.sv
// Lane-side sensors/keypads in, barrier and indicator state out.
// Handshake: there is no valid/ready pair; every input is a level sampled on
// the rising clock edge, a submit is the rising edge of enterPin for the
// granted lane, and every output is a registered level updated one cycle
// after the input that caused it.
interface arbitro_compuerta_if #(
  parameter int ANCHO_FALLOS = 3
);
  import arbitro_pkg::*;

  logic [1:0]              Vehiculo;
  logic [1:0]              Termino;
  logic [1:0]              enterPin;
  logic [7:0]              Pin0;
  logic [7:0]              Pin1;
  logic [1:0]              Grant;
  logic                    Cerrado;
  logic                    Abierto;
  logic                    Alarma;
  logic                    Bloqueo;
  logic [ANCHO_FALLOS-1:0] Fallos;
  estado_t                 estado;

  // Lane side: drives the sensors and keypads.
  modport master (
    output Vehiculo, Termino, enterPin, Pin0, Pin1,
    input  Grant, Cerrado, Abierto, Alarma, Bloqueo, Fallos, estado
  );

  // Controller side.
  modport slave (
    input  Vehiculo, Termino, enterPin, Pin0, Pin1,
    output Grant, Cerrado, Abierto, Alarma, Bloqueo, Fallos, estado
  );

endinterface

// File: rtl/rr_arbitro_2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// request; the pointer only moves when the owner releases the barrier, and
// then it points at the lane that was not last served.
module rr_arbitro_2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;   // 0 favours lane 0, 1 favours lane 1
  logic last_q;  // lane index of the most recent grant

  // Pick a single requester; on a tie the pointer decides.
  always_comb begin
    grant = request;
    if (request == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Remember who was served and hand priority to the other lane on release.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (|request) begin
        last_q <= grant[1];
      end
      if (advance) begin
        ptr_q <= ~last_q;
      end
    end
  end

endmodule

// File: rtl/arbitro_compuerta.sv
// Barrier sequencing controller: grants one lane, checks its PIN, counts
// wrong attempts and drives barrier/alarm/lockout outputs.
module arbitro_compuerta
  import arbitro_pkg::*;
#(
  parameter logic [7:0] PIN_CORRECTO = PIN_DEFAULT,
  parameter int         MAX_INTENTOS = 3,
  parameter int         ANCHO_FALLOS = 3
) (
  input logic               Clk,
  input logic               Reset,
  arbitro_compuerta_if.slave bus
);

  localparam logic [ANCHO_FALLOS-1:0] MAX_F = ANCHO_FALLOS'(MAX_INTENTOS);

  estado_t                 state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic [ANCHO_FALLOS-1:0] fallos_q, fallos_d, fallos_inc;
  logic [1:0]              enter_q;
  logic                    cerrado_q, abierto_q, alarma_q, bloqueo_q;
  logic [1:0]              arb_req, arb_grant;
  logic                    advance;
  logic                    submit, veh_g, term_g, pin_ok;
  logic [7:0]              pin_g;

  // The arbiter only sees requests while the barrier is free.
  assign arb_req = (state_q == CERRADO) ? bus.Vehiculo : 2'b00;

  rr_arbitro_2 u_rr (
    .Clk     (Clk),
    .Reset   (Reset),
    .request (arb_req),
    .advance (advance),
    .grant   (arb_grant)
  );

  // Everything below is masked by the current owner, so the other lane's
  // strobes, pulses and keypad never reach the FSM.
  assign submit = |(bus.enterPin & ~enter_q & grant_q);
  assign veh_g  = |(bus.Vehiculo & grant_q);
  assign term_g = |(bus.Termino & grant_q);
  assign pin_g  = grant_q[LANE1] ? bus.Pin1 : bus.Pin0;
  assign pin_ok = (pin_g == PIN_CORRECTO);

  // Wrong-attempt counter saturates at the alarm threshold.
  assign fallos_inc = (fallos_q >= MAX_F) ? fallos_q : fallos_q + 1'b1;

  // Next-state, next-grant and next-counter decode.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    fallos_d = fallos_q;
    advance  = 1'b0;
    case (state_q)
      CERRADO: begin
        if (|bus.Vehiculo) begin
          state_d = ESPERA_PIN;
          grant_d = arb_grant;
        end
      end
      ESPERA_PIN: begin
        if (submit) begin
          if (pin_ok) begin
            state_d  = ABIERTO;
            fallos_d = '0;
          end else begin
            fallos_d = fallos_inc;
            if (fallos_inc >= MAX_F) begin
              state_d = ALARMA;
            end
          end
        end else if (!veh_g) begin
          state_d  = CERRADO;
          grant_d  = 2'b00;
          fallos_d = '0;
        end
      end
      ALARMA: begin
        // A vanished vehicle does not clear the alarm; only a good PIN does.
        if (submit) begin
          if (pin_ok) begin
            state_d  = ABIERTO;
            fallos_d = '0;
          end else begin
            fallos_d = fallos_inc;
          end
        end
      end
      ABIERTO: begin
        if (term_g) begin
          if (veh_g) begin
            state_d = BLOQUEO;
          end else begin
            state_d = CERRADO;
            grant_d = 2'b00;
            advance = 1'b1;
          end
        end
      end
      BLOQUEO: begin
        state_d = BLOQUEO;
      end
      default: begin
        state_d  = CERRADO;
        grant_d  = 2'b00;
        fallos_d = '0;
      end
    endcase
  end

  // State, counter, edge-detect history and registered Moore outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= CERRADO;
      grant_q   <= 2'b00;
      fallos_q  <= '0;
      enter_q   <= 2'b00;
      cerrado_q <= 1'b1;
      abierto_q <= 1'b0;
      alarma_q  <= 1'b0;
      bloqueo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      fallos_q  <= fallos_d;
      enter_q   <= bus.enterPin;
      cerrado_q <= (state_d != ABIERTO);
      abierto_q <= (state_d == ABIERTO);
      alarma_q  <= (state_d == ALARMA);
      bloqueo_q <= (state_d == BLOQUEO);
    end
  end

  assign bus.Grant   = grant_q;
  assign bus.Cerrado = cerrado_q;
  assign bus.Abierto = abierto_q;
  assign bus.Alarma  = alarma_q;
  assign bus.Bloqueo = bloqueo_q;
  assign bus.Fallos  = fallos_q;
  assign bus.estado  = state_q;

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Directed bench for arbitro_compuerta: the driver pushes the hand-computed
// response expected after each stimulus cycle; a monitor pops and compares.
module tb_arbitro_compuerta;
  import arbitro_pkg::*;

  localparam int W = 12;

  logic Clk;
  logic Reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];

  arbitro_compuerta_if #(.ANCHO_FALLOS(3)) bus ();

  arbitro_compuerta #(
    .PIN_CORRECTO (8'h10),
    .MAX_INTENTOS (3),
    .ANCHO_FALLOS (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input estado_t s, input logic [1:0] g,
                                      input logic [2:0] f);
    return {s, g, (s != ABIERTO), (s == ABIERTO), (s == ALARMA),
            (s == BLOQUEO), f};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] v, input logic [1:0] t,
                       input logic [1:0] e, input logic [7:0] p0,
                       input logic [7:0] p1);
    @(negedge Clk);
    bus.Vehiculo = v;
    bus.Termino  = t;
    bus.enterPin = e;
    bus.Pin0     = p0;
    bus.Pin1     = p1;
  endtask

  // Expected response after the next rising edge.
  task automatic chk(input string n, input estado_t s, input logic [1:0] g,
                     input logic [2:0] f);
    exp_q.push_back(mk(s, g, f));
    cyc_q.push_back(cyc + 1);
    name_q.push_back(n);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset        = 1'b0;
    bus.Vehiculo = 2'b00;
    bus.Termino  = 2'b00;
    bus.enterPin = 2'b00;
    bus.Pin0     = 8'h00;
    bus.Pin1     = 8'h00;
    chk("reset", CERRADO, 2'b00, 3'd0);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    string        nm;
    obs = {bus.estado, bus.Grant, bus.Cerrado, bus.Abierto, bus.Alarma,
           bus.Bloqueo, bus.Fallos};
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      void'(cyc_q.pop_front());
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got st=%0d g=%b c=%b a=%b al=%b b=%b f=%0d, want st=%0d g=%b c=%b a=%b al=%b b=%b f=%0d",
                 nm, obs[11:9], obs[8:7], obs[6], obs[5], obs[4], obs[3], obs[2:0],
                 exp_v[11:9], exp_v[8:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3], exp_v[2:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc          = 0;
    n_tests      = 0;
    n_fail       = 0;
    Reset        = 1'b0;
    bus.Vehiculo = 2'b00;
    bus.Termino  = 2'b00;
    bus.enterPin = 2'b00;
    bus.Pin0     = 8'h00;
    bus.Pin1     = 8'h00;
    repeat (2) @(negedge Clk);
    do_reset();

    // Basic open/close on lane 0.
    drive(2'b01, 2'b00, 2'b00, 8'h00, 8'h00); chk("t1_grant", ESPERA_PIN, 2'b01, 3'd0);
    drive(2'b01, 2'b00, 2'b01, 8'h10, 8'h00); chk("t1_open",  ABIERTO,    2'b01, 3'd0);
    drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00); chk("t1_hold",  ABIERTO,    2'b01, 3'd0);
    drive(2'b00, 2'b01, 2'b00, 8'h10, 8'h00); chk("t1_close", CERRADO,    2'b00, 3'd0);
    drive(2'b00, 2'b00, 2'b00, 8'h10, 8'h00);

    // Wrong attempts, alarm, saturation, alarm survives vehicle loss.
    drive(2'b01, 2'b00, 2'b00, 8'hFF, 8'h00); chk("t2_grant", ESPERA_PIN, 2'b01, 3'd0);
    drive(2'b01, 2'b00, 2'b01, 8'hFF, 8'h00); chk("t2_f1",    ESPERA_PIN, 2'b01, 3'd1);
    drive(2'b01, 2'b00, 2'b00, 8'hFF, 8'h00);
    drive(2'b01, 2'b00, 2'b01, 8'hFF, 8'h00); chk("t2_f2",    ESPERA_PIN, 2'b01, 3'd2);
    drive(2'b01, 2'b00, 2'b00, 8'hFF, 8'h00);
    drive(2'b01, 2'b00, 2'b01, 8'hFF, 8'h00); chk("t2_alarm", ALARMA,     2'b01, 3'd3);
    drive(2'b01, 2'b00, 2'b00, 8'hFF, 8'h00);
    drive(2'b01, 2'b00, 2'b01, 8'hFF, 8'h00); chk("t2_sat",   ALARMA,     2'b01, 3'd3);
    drive(2'b00, 2'b00, 2'b00, 8'hFF, 8'h00); chk("t2_vdrop", ALARMA,     2'b01, 3'd3);
    drive(2'b00, 2'b00, 2'b01, 8'h10, 8'h00); chk("t2_open",  ABIERTO,    2'b01, 3'd0);
    drive(2'b00, 2'b10, 2'b00, 8'h10, 8'h00); chk("t2_term_other", ABIERTO, 2'b01, 3'd0);
    drive(2'b00, 2'b01, 2'b00, 8'h10, 8'h00); chk("t2_close", CERRADO,    2'b00, 3'd0);
    drive(2'b00, 2'b00, 2'b00, 8'h10, 8'h00);

    // Held strobe counts once; Pin change without an edge is ignored.
    drive(2'b01, 2'b00, 2'b00, 8'hFF, 8'h00); chk("t3_grant", ESPERA_PIN, 2'b01, 3'd0);
    drive(2'b01, 2'b00, 2'b01, 8'hFF, 8'h00); chk("t3_f1",    ESPERA_PIN, 2'b01, 3'd1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 2'b00, 2'b01, 8'hFF, 8'h00); chk("t3_held", ESPERA_PIN, 2'b01, 3'd1);
    end
    drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00); chk("t3_pin_noedge", ESPERA_PIN, 2'b01, 3'd1);
    drive(2'b01, 2'b00, 2'b00, 8'h33, 8'h00); chk("t3_pin_chg",    ESPERA_PIN, 2'b01, 3'd1);
    drive(2'b00, 2'b00, 2'b00, 8'h33, 8'h00); chk("t3_leave", CERRADO,    2'b00, 3'd0);

    // Round robin with both lanes requesting.
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 8'h00, 8'h00); chk("t4_rr0",   ESPERA_PIN, 2'b01, 3'd0);
    drive(2'b11, 2'b00, 2'b01, 8'h10, 8'h00); chk("t4_open0", ABIERTO,    2'b01, 3'd0);
    drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h00);
    drive(2'b10, 2'b01, 2'b00, 8'h10, 8'h00); chk("t4_close0", CERRADO,   2'b00, 3'd0);
    drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h00); chk("t4_rr1",   ESPERA_PIN, 2'b10, 3'd0);
    drive(2'b11, 2'b00, 2'b10, 8'h00, 8'h10); chk("t4_open1", ABIERTO,    2'b10, 3'd0);
    drive(2'b11, 2'b00, 2'b00, 8'h00, 8'h10);
    drive(2'b01, 2'b10, 2'b00, 8'h00, 8'h10); chk("t4_close1", CERRADO,   2'b00, 3'd0);
    drive(2'b11, 2'b00, 2'b00, 8'h00, 8'h00); chk("t4_rr0b",  ESPERA_PIN, 2'b01, 3'd0);

    // Lockout is sticky until reset.
    drive(2'b11, 2'b00, 2'b01, 8'h10, 8'h00); chk("t5_open",  ABIERTO,    2'b01, 3'd0);
    drive(2'b11, 2'b00, 2'b00, 8'h10, 8'h00);
    drive(2'b11, 2'b01, 2'b00, 8'h10, 8'h00); chk("t5_lock",  BLOQUEO,    2'b01, 3'd0);
    drive(2'b11, 2'b00, 2'b01, 8'h10, 8'h00); chk("t5_lock_pin", BLOQUEO, 2'b01, 3'd0);
    drive(2'b00, 2'b00, 2'b00, 8'h10, 8'h00); chk("t5_lock_idle", BLOQUEO, 2'b01, 3'd0);
    do_reset();

    // Non-granted lane is ignored; lane 1 abandons.
    drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h00); chk("t6_grant1", ESPERA_PIN, 2'b10, 3'd0);
    drive(2'b10, 2'b00, 2'b01, 8'h10, 8'h00); chk("t6_other",  ESPERA_PIN, 2'b10, 3'd0);
    drive(2'b10, 2'b00, 2'b00, 8'h10, 8'h00);
    drive(2'b10, 2'b00, 2'b10, 8'h10, 8'hFF); chk("t6_f1",     ESPERA_PIN, 2'b10, 3'd1);
    drive(2'b10, 2'b00, 2'b00, 8'h10, 8'hFF);
    drive(2'b00, 2'b00, 2'b00, 8'h10, 8'hFF); chk("t6_leave",  CERRADO,    2'b00, 3'd0);

    repeat (3) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_compuerta.md
Name: arbitro_compuerta

Overview:
- Sequencing controller that shares one parking barrier between two entry lanes, each with its own vehicle sensor, PIN keypad and passage sensor.
- Grants the barrier to one lane at a time using round-robin priority.
- Checks the granted lane's PIN and counts wrong attempts.
- Drives barrier state, alarm and lockout outputs for the gate-level logic and indicators downstream.

Parameters:
- PIN_CORRECTO, 8'h10, PIN that opens the barrier for either lane.
- MAX_INTENTOS, 3, wrong attempts in one session that raise Alarma.
- ANCHO_FALLOS, 3, width of the wrong-attempt counter; must satisfy 2^ANCHO_FALLOS-1 >= MAX_INTENTOS.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Vehiculo  input  2  per-lane vehicle-present sensor; bit i = lane i.
- Termino  input  2  per-lane "vehicle finished passing" pulse.
- enterPin  input  2  per-lane PIN-submit strobe; level, held one or more cycles.
- Pin0  input  8  lane 0 keypad value, sampled only on the submit edge.
- Pin1  input  8  lane 1 keypad value, sampled only on the submit edge.
- Grant  output  2  one-hot lane currently owning the barrier; 2'b00 = none.
- Cerrado  output  1  barrier closed.
- Abierto  output  1  barrier open.
- Alarma  output  1  wrong-attempt alarm.
- Bloqueo  output  1  lockout, sticky.
- Fallos  output  ANCHO_FALLOS  wrong attempts in the current session, saturating.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State CERRADO, Grant=00, Cerrado=1, Abierto=Alarma=Bloqueo=0, Fallos=0.
  - Round-robin pointer favours lane 0; enterPin edge-detect history cleared.
  - Reset asserted mid-operation aborts everything immediately, including BLOQUEO.
- Outputs are registered Moore outputs; every transition becomes visible one cycle after the input edge that caused it.
- Submit event: rising edge of enterPin[g] for the granted lane g, detected against a registered copy.
  - A held level counts once.
  - enterPin of the non-granted lane is ignored, and so is any Pin change without an edge.
- State CERRADO (Cerrado=1):
  - Any Vehiculo bit set -> grant that lane, go ESPERA_PIN.
  - Both bits set -> grant the lane favoured by the pointer.
- State ESPERA_PIN (Cerrado=1):
  - Submit with PinG==PIN_CORRECTO -> ABIERTO; Fallos=0.
  - Submit with wrong PIN -> Fallos+1, saturating. Reaching MAX_INTENTOS -> ALARMA.
  - Vehiculo[g]=0 with no submit -> CERRADO; Grant=00, Fallos=0, pointer unchanged.
- State ALARMA (Cerrado=1, Alarma=1):
  - Further wrong submits keep incrementing Fallos, saturating.
  - Correct submit -> ABIERTO; Alarma=0, Fallos=0.
  - Vehiculo[g]=0 -> stay in ALARMA with Grant held; only a correct PIN or reset clears it.
- State ABIERTO (Abierto=1, Cerrado=0):
  - Termino[g]=1 and Vehiculo[g]=0 -> CERRADO; Grant=00, pointer moves to the other lane.
  - Termino[g]=1 and Vehiculo[g]=1 in the same cycle -> BLOQUEO.
  - Other lane's requests stay pending and are served from CERRADO next cycle.
- State BLOQUEO (Bloqueo=1, Cerrado=1, Abierto=0, Alarma=0, Grant held): all inputs ignored; exit only via reset.
- Invariants:
  - Cerrado and Abierto are never 1 together.
  - Grant is at most one-hot and nonzero in every state except CERRADO.
- Termino of the non-granted lane is ignored in all states.

Decomposition:
- Package arbitro_pkg:
  - state enum: CERRADO, ESPERA_PIN, ALARMA, ABIERTO, BLOQUEO.
  - lane index constants LANE0/LANE1.
  - default PIN constant.
- Sub-module rr_arbitro_2:
  - inputs: 2-bit request, pointer-advance strobe.
  - output: one-hot grant.
  - holds the priority pointer register.
- The top FSM, attempt counter and edge detectors live in arbitro_compuerta.

Test Plan:
- Reset, then Vehiculo=01 -> Grant=01. Submit Pin0=8'h10 -> Abierto=1 next cycle. Termino=01 with Vehiculo=00 -> Cerrado=1, Grant=00.
- Lane 0 submits 8'hFF three times -> Fallos=1,2,3 and Alarma=1 after the third. A fourth wrong submit -> Fallos stays 3. Submit 8'h10 -> Alarma=0, Abierto=1, Fallos=0.
- Lane 0 holds enterPin=1 for 4 cycles with Pin0=8'hFF -> Fallos=1 only. A Pin0 change with enterPin=0 -> no change.
- Vehiculo=11 from reset -> Grant=01. Lane 0 completes -> next grant is 10. A second simultaneous request after that -> Grant=01.
- In ABIERTO, Termino=01 with Vehiculo=01 -> Bloqueo=1, Cerrado=1. A correct PIN after that -> no change. Reset=0 -> state CERRADO, Bloqueo=0.
- In ESPERA_PIN for lane 1, lane 0 submits 8'h10 -> ignored. Vehiculo[1] drops -> Grant=00, Fallos=0.
